// File: rtl/rr_stream_mux2_if.sv
// Handshake bundle for the two-producer round-robin stream mux.
// The mux side uses the slave modport; producers and the consumer sit on master.
interface rr_stream_mux2_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] i0_data;
  logic             i0_valid;
  logic             i0_last;
  logic             i0_ready;
  logic [WIDTH-1:0] i1_data;
  logic             i1_valid;
  logic             i1_last;
  logic             i1_ready;
  logic [WIDTH-1:0] y_data;
  logic             y_valid;
  logic             y_last;
  logic             y_ready;

  modport master (
    output i0_data, i0_valid, i0_last,
    output i1_data, i1_valid, i1_last,
    output y_ready,
    input  i0_ready, i1_ready,
    input  y_data, y_valid, y_last
  );

  modport slave (
    input  i0_data, i0_valid, i0_last,
    input  i1_data, i1_valid, i1_last,
    input  y_ready,
    output i0_ready, i1_ready,
    output y_data, y_valid, y_last
  );
endinterface

// File: rtl/rr_stream_mux2.sv
// Two-input packet-aware round-robin stream mux with a registered output beat.
// A granted packet keeps the channel until its last beat is accepted.
module rr_stream_mux2 #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  rr_stream_mux2_if.slave bus,
  output logic            sel,
  output logic            busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOCK0 = 2'd1;
  localparam logic [1:0] LOCK1 = 2'd2;

  logic [1:0]       state;
  logic             prio;
  logic [WIDTH-1:0] y_data_q;
  logic             y_valid_q;
  logic             y_last_q;

  logic             load_ok;
  logic             acc;
  logic             sel_valid;
  logic             sel_last;
  logic             sel_ready;
  logic [WIDTH-1:0] sel_data;

  // A lone requester in IDLE wins outright; otherwise prio decides.
  always_comb begin
    sel = prio;
    case (state)
      LOCK0:   sel = 1'b0;
      LOCK1:   sel = 1'b1;
      default: begin
        if (bus.i0_valid != bus.i1_valid) sel = bus.i1_valid;
        else                              sel = prio;
      end
    endcase
  end

  assign load_ok = !y_valid_q || bus.y_ready;

  // Readies are gated by rst_n so nothing is accepted while reset is held.
  assign bus.i0_ready = rst_n && load_ok && !sel && (state != LOCK1);
  assign bus.i1_ready = rst_n && load_ok &&  sel && (state != LOCK0);

  assign sel_valid = sel ? bus.i1_valid : bus.i0_valid;
  assign sel_last  = sel ? bus.i1_last  : bus.i0_last;
  assign sel_data  = sel ? bus.i1_data  : bus.i0_data;
  assign sel_ready = sel ? bus.i1_ready : bus.i0_ready;
  assign acc       = sel_valid && sel_ready;

  assign busy = (state == LOCK0) || (state == LOCK1);

  assign bus.y_data  = y_data_q;
  assign bus.y_valid = y_valid_q;
  assign bus.y_last  = y_last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prio      <= 1'b0;
      y_data_q  <= '0;
      y_valid_q <= 1'b0;
      y_last_q  <= 1'b0;
    end else begin
      if (acc) begin
        y_data_q  <= sel_data;
        y_last_q  <= sel_last;
        y_valid_q <= 1'b1;
        // Finishing a packet hands the next tie-break to the other input.
        if (sel_last) begin
          state <= IDLE;
          prio  <= ~sel;
        end else begin
          state <= sel ? LOCK1 : LOCK0;
        end
      end else if (bus.y_ready) begin
        y_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_stream_mux2.sv
// Directed bench for rr_stream_mux2: expected output beats are queued as stimulus
// is planned and compared whenever the consumer takes a beat.
module tb_rr_stream_mux2;
  localparam int WIDTH = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic sel;
  logic busy;
  int   checks = 0;
  int   errors = 0;
  logic acc0;
  logic acc1;
  logic [WIDTH:0] exp_q[$];

  rr_stream_mux2_if #(.WIDTH(WIDTH)) bus ();

  rr_stream_mux2 #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .sel   (sel),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [WIDTH-1:0] d0, input logic l0,
                               input logic v1, input logic [WIDTH-1:0] d1, input logic l1,
                               input logic yr);
    bus.i0_valid = v0;
    bus.i0_data  = d0;
    bus.i0_last  = l0;
    bus.i1_valid = v1;
    bus.i1_data  = d1;
    bus.i1_last  = l1;
    bus.y_ready  = yr;
    #1;
  endtask

  // Records which input handshakes at the coming edge, then lands just past it.
  task automatic nextCycle();
    @(negedge clk);
    acc0 = bus.i0_valid && bus.i0_ready;
    acc1 = bus.i1_valid && bus.i1_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Consumer side: a beat leaves at the next edge when valid and ready are both high.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.y_valid === 1'b1 && bus.y_ready === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("[TB] FAIL unexpected_beat: observed=%0h expected=none", {bus.y_last, bus.y_data});
      end
      if (exp_q.size() != 0)
        checkOutput("beat", 32'({bus.y_last, bus.y_data}), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    bus.i0_valid = 1'b1;
    #1;
    checkOutput("rst_y_valid", 32'(bus.y_valid), 0);
    checkOutput("rst_y_data", 32'(bus.y_data), 0);
    checkOutput("rst_y_last", 32'(bus.y_last), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_i0_ready", 32'(bus.i0_ready), 0);
    checkOutput("rst_i1_ready", 32'(bus.i1_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] single producer, 3-beat packet");
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b0, 8'h22});
    exp_q.push_back({1'b1, 8'h33});
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 8'hxx, 1'bx, 1'b1);
    checkOutput("t1_sel", 32'(sel), 0);
    checkOutput("t1_i0_ready", 32'(bus.i0_ready), 1);
    nextCycle();
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0, 8'hxx, 1'bx, 1'b1);
    checkOutput("t1_busy_a", 32'(busy), 1);
    checkOutput("t1_y_data_a", 32'(bus.y_data), 32'h11);
    nextCycle();
    applyStimulus(1'b1, 8'h33, 1'b1, 1'b0, 8'hxx, 1'bx, 1'b1);
    checkOutput("t1_busy_b", 32'(busy), 1);
    checkOutput("t1_sel_b", 32'(sel), 0);
    nextCycle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("t1_busy_end", 32'(busy), 0);
    checkOutput("t1_y_last", 32'(bus.y_last), 1);
    nextCycle();
    checkOutput("t1_y_valid_idle", 32'(bus.y_valid), 0);

    $display("[TB] simultaneous 2-beat packets from reset");
    doReset();
    exp_q.push_back({1'b0, 8'hA0});
    exp_q.push_back({1'b1, 8'hA1});
    exp_q.push_back({1'b0, 8'hB0});
    exp_q.push_back({1'b1, 8'hB1});
    applyStimulus(1'b1, 8'hA0, 1'b0, 1'b1, 8'hB0, 1'b0, 1'b1);
    checkOutput("t2_sel", 32'(sel), 0);
    checkOutput("t2_i1_ready_a", 32'(bus.i1_ready), 0);
    nextCycle();
    applyStimulus(1'b1, 8'hA1, 1'b1, 1'b1, 8'hB0, 1'b0, 1'b1);
    checkOutput("t2_i1_ready_b", 32'(bus.i1_ready), 0);
    nextCycle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'hB0, 1'b0, 1'b1);
    checkOutput("t2_sel_b", 32'(sel), 1);
    checkOutput("t2_i1_ready_c", 32'(bus.i1_ready), 1);
    nextCycle();
    applyStimulus(1'b1, 8'hEE, 1'b1, 1'b1, 8'hB1, 1'b1, 1'b1);
    checkOutput("t2_i0_ready_lock1", 32'(bus.i0_ready), 0);
    nextCycle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    nextCycle();

    $display("[TB] continuous contention, single-beat packets");
    begin
      logic [WIDTH-1:0] n0;
      logic [WIDTH-1:0] n1;
      n0 = 8'h40;
      n1 = 8'h80;
      for (int i = 0; i < 3; i++) begin
        exp_q.push_back({1'b1, 8'(8'h40 + i)});
        exp_q.push_back({1'b1, 8'(8'h80 + i)});
      end
      for (int i = 0; i < 6; i++) begin
        applyStimulus(1'b1, n0, 1'b1, 1'b1, n1, 1'b1, 1'b1);
        nextCycle();
        checkOutput("t3_grant_i0", 32'(acc0), 32'(i % 2 == 0));
        checkOutput("t3_grant_i1", 32'(acc1), 32'(i % 2 == 1));
        if (acc0) n0 = n0 + 8'd1;
        if (acc1) n1 = n1 + 8'd1;
      end
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      nextCycle();
    end

    $display("[TB] lock held while owner pauses mid-packet");
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b1, 8'h02});
    exp_q.push_back({1'b1, 8'hC0});
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b1, 8'hC0, 1'b1, 1'b1);
    checkOutput("t4_sel", 32'(sel), 0);
    nextCycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'hC0, 1'b1, 1'b1);
      checkOutput("t4_i1_ready_hold", 32'(bus.i1_ready), 0);
      checkOutput("t4_busy_hold", 32'(busy), 1);
      nextCycle();
    end
    applyStimulus(1'b1, 8'h02, 1'b1, 1'b1, 8'hC0, 1'b1, 1'b1);
    checkOutput("t4_i0_ready_resume", 32'(bus.i0_ready), 1);
    nextCycle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'hC0, 1'b1, 1'b1);
    checkOutput("t4_sel_after", 32'(sel), 1);
    checkOutput("t4_i1_ready_after", 32'(bus.i1_ready), 1);
    nextCycle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    nextCycle();

    $display("[TB] output backpressure");
    exp_q.push_back({1'b1, 8'h5A});
    exp_q.push_back({1'b1, 8'h5B});
    applyStimulus(1'b1, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    nextCycle();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 8'h5B, 1'b1, 1'b1, 8'h77, 1'b1, 1'b0);
      checkOutput("t5_y_data_hold", 32'(bus.y_data), 32'h5A);
      checkOutput("t5_y_valid_hold", 32'(bus.y_valid), 1);
      checkOutput("t5_i0_ready_bp", 32'(bus.i0_ready), 0);
      checkOutput("t5_i1_ready_bp", 32'(bus.i1_ready), 0);
      nextCycle();
    end
    applyStimulus(1'b1, 8'h5B, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("t5_i0_ready_release", 32'(bus.i0_ready), 1);
    nextCycle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("t5_no_bubble_data", 32'(bus.y_data), 32'h5B);
    checkOutput("t5_no_bubble_valid", 32'(bus.y_valid), 1);
    nextCycle();

    $display("[TB] asynchronous reset while locked on i1");
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'hD0, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("t6_busy_locked", 32'(busy), 1);
    checkOutput("t6_sel_locked", 32'(sel), 1);
    checkOutput("t6_y_valid_held", 32'(bus.y_valid), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_y_valid_rst", 32'(bus.y_valid), 0);
    checkOutput("t6_busy_rst", 32'(busy), 0);
    checkOutput("t6_i0_ready_rst", 32'(bus.i0_ready), 0);
    nextCycle();
    rst_n = 1'b1;
    exp_q.push_back({1'b1, 8'hE0});
    exp_q.push_back({1'b1, 8'hF0});
    applyStimulus(1'b1, 8'hE0, 1'b1, 1'b1, 8'hF0, 1'b1, 1'b1);
    checkOutput("t6_sel_fresh", 32'(sel), 0);
    checkOutput("t6_i1_ready_fresh", 32'(bus.i1_ready), 0);
    nextCycle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'hF0, 1'b1, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    nextCycle();
    nextCycle();

    checkOutput("drain", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
